// File: rtl/pq_pkg.sv
// Shared types for the sorted priority queue: operation decode and
// per-slot source select.
package pq_pkg;

    typedef enum logic [2:0] {
        PQ_NOP,
        PQ_INSERT,
        PQ_POP,
        PQ_REPLACE,
        PQ_CLEAR
    } pq_op_t;

    typedef enum logic [1:0] {
        HOLD,
        FROM_PREV,
        FROM_NEXT,
        LOAD_NEW
    } pq_sel_t;

endpackage

// File: rtl/pq_slot.sv
// One priority-queue entry: data plus valid bit with a 4-way source
// select (hold, shift down from previous, shift up from next, load new).
module pq_slot
    import pq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         ck,
    input  logic         r,
    input  pq_sel_t      i_sel,
    input  logic         i_clr,
    input  logic [W-1:0] i_prev_d,
    input  logic         i_prev_v,
    input  logic [W-1:0] i_next_d,
    input  logic         i_next_v,
    input  logic [W-1:0] i_new_d,
    output logic [W-1:0] o_d,
    output logic         o_v
);

    logic [W-1:0] r_d;
    logic         r_v;

    always_ff @(posedge ck or negedge r) begin
        if (!r) begin
            r_d <= '0;
            r_v <= 1'b0;
        end else if (i_clr) begin
            r_v <= 1'b0;
        end else begin
            unique case (i_sel)
                HOLD: ;
                FROM_PREV: begin
                    r_d <= i_prev_d;
                    r_v <= i_prev_v;
                end
                FROM_NEXT: begin
                    r_d <= i_next_d;
                    r_v <= i_next_v;
                end
                LOAD_NEW: begin
                    r_d <= i_new_d;
                    r_v <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_d = r_d;
    assign o_v = r_v;

endmodule

// File: rtl/pq_sorted.sv
// Sorted shift-register priority queue; slot 0 is always the best entry.
// Define PQ_MIN_EN for a min-queue, otherwise it is a max-queue.
module pq_sorted
    import pq_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 6
) (
    input  logic                       ck,
    input  logic                       r,
    input  logic [W-1:0]               newVal,
    input  logic                       loadIn,
    input  logic                       shiftOut,
    input  logic                       clear,
    output logic [W-1:0]               top,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]     w_d [DEPTH];
    logic [DEPTH-1:0] w_v;
    logic [DEPTH-1:0] w_below;
    logic [DEPTH-1:0] w_bp;
    logic [DEPTH-1:0] w_bn;
    logic [DEPTH-1:0] w_bz;
    pq_sel_t          w_sel [DEPTH];
    pq_op_t           w_op;
    logic             w_empty;
    logic             w_full;
    logic [CW-1:0]    r_count;
    logic             r_ovf;
    logic             r_unf;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));

    // w_below[i]: newVal belongs after valid slot i (ties keep arrival order)
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
`ifdef PQ_MIN_EN
            w_below[i] = w_v[i] && !(newVal < w_d[i]);
`else
            w_below[i] = w_v[i] && !(newVal > w_d[i]);
`endif
        end
    end

    assign w_bp = {w_below[DEPTH-2:0], 1'b1};
    assign w_bn = {1'b0, w_below[DEPTH-1:1]};
    assign w_bz = {w_below[DEPTH-1:1], 1'b1};

    always_comb begin
        w_op = PQ_NOP;
        unique case (1'b1)
            clear:                          w_op = PQ_CLEAR;
            !clear && loadIn && shiftOut:   w_op = PQ_REPLACE;
            !clear && loadIn && !shiftOut:  w_op = PQ_INSERT;
            !clear && !loadIn && shiftOut:  w_op = PQ_POP;
            default:                        w_op = PQ_NOP;
        endcase
    end

    // Replace drops slot 0, so the search window starts at slot 1
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_sel[i] = HOLD;
            unique case (w_op)
                PQ_INSERT:
                    w_sel[i] = w_below[i] ? HOLD :
                               w_bp[i]    ? LOAD_NEW : FROM_PREV;
                PQ_POP:
                    w_sel[i] = w_empty ? HOLD : FROM_NEXT;
                PQ_REPLACE:
                    w_sel[i] = w_bn[i] ? FROM_NEXT :
                               w_bz[i] ? LOAD_NEW : HOLD;
                default:
                    w_sel[i] = HOLD;
            endcase
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        logic [W-1:0] w_pd;
        logic         w_pv;
        logic [W-1:0] w_nd;
        logic         w_nv;

        if (g == 0) begin : g_first
            assign w_pd = '0;
            assign w_pv = 1'b0;
        end else begin : g_mid
            assign w_pd = w_d[g-1];
            assign w_pv = w_v[g-1];
        end

        if (g == DEPTH-1) begin : g_last
            assign w_nd = '0;
            assign w_nv = 1'b0;
        end else begin : g_body
            assign w_nd = w_d[g+1];
            assign w_nv = w_v[g+1];
        end

        pq_slot #(.W(W)) u_slot (
            .ck       (ck),
            .r        (r),
            .i_sel    (w_sel[g]),
            .i_clr    (w_op == PQ_CLEAR),
            .i_prev_d (w_pd),
            .i_prev_v (w_pv),
            .i_next_d (w_nd),
            .i_next_v (w_nv),
            .i_new_d  (newVal),
            .o_d      (w_d[g]),
            .o_v      (w_v[g])
        );
    end

    always_ff @(posedge ck or negedge r) begin
        if (!r) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
            unique case (w_op)
                PQ_CLEAR:
                    r_count <= '0;
                PQ_INSERT:
                    if (w_full) r_ovf <= 1'b1;
                    else        r_count <= r_count + 1'b1;
                PQ_POP:
                    if (w_empty) r_unf <= 1'b1;
                    else         r_count <= r_count - 1'b1;
                PQ_REPLACE:
                    if (w_empty) r_count <= CW'(1);
                default: ;
            endcase
        end
    end

    assign top       = w_v[0] ? w_d[0] : '0;
    assign empty     = w_empty;
    assign full      = w_full;
    assign count     = r_count;
    assign overflow  = r_ovf;
    assign underflow = r_unf;

endmodule

// File: tb/tb_pq_sorted.sv
// Scoreboard bench for pq_sorted (W=8, DEPTH=4); follows PQ_MIN_EN
// so the same bench covers both queue directions.
module tb_pq_sorted;

    localparam int W     = 8;
    localparam int DEPTH = 4;

    logic         ck = 1'b0;
    logic         r = 1'b0;
    logic [W-1:0] newVal = '0;
    logic         loadIn = 1'b0;
    logic         shiftOut = 1'b0;
    logic         clear = 1'b0;
    logic [W-1:0] top;
    logic         empty;
    logic         full;
    logic [2:0]   count;
    logic         overflow;
    logic         underflow;

    int checks = 0;
    int errors = 0;
    int m[$];
    int sb[$];
    bit e_ovf;
    bit e_unf;
    int popped;

    pq_sorted #(.W(W), .DEPTH(DEPTH)) dut (
        .ck        (ck),
        .r         (r),
        .newVal    (newVal),
        .loadIn    (loadIn),
        .shiftOut  (shiftOut),
        .clear     (clear),
        .top       (top),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 ck = ~ck;

    function automatic bit better(int a, int b);
`ifdef PQ_MIN_EN
        return a < b;
`else
        return a > b;
`endif
    endfunction

    function automatic int kpos(int v);
        for (int i = 0; i < m.size(); i++)
            if (better(v, m[i])) return i;
        return m.size();
    endfunction

    function automatic int mtop();
        return (m.size() > 0) ? m[0] : 0;
    endfunction

    task automatic model(bit ld, bit sh, bit cl, int v);
        int k;
        e_ovf = 0;
        e_unf = 0;
        if (cl) begin
            m.delete();
        end else if (ld && sh) begin
            if (m.size() > 0) void'(m.pop_front());
            m.insert(kpos(v), v);
        end else if (ld) begin
            k = kpos(v);
            if (m.size() == DEPTH) begin
                e_ovf = 1;
                if (k < DEPTH) begin
                    m.insert(k, v);
                    void'(m.pop_back());
                end
            end else begin
                m.insert(k, v);
            end
        end else if (sh) begin
            if (m.size() == 0) e_unf = 1;
            else void'(m.pop_front());
        end
    endtask

    task automatic step(bit ld, bit sh, bit cl, int v);
        @(negedge ck);
        loadIn   = ld;
        shiftOut = sh;
        clear    = cl;
        newVal   = W'(v);
        popped   = int'(top);
        if (sh && !ld && !cl && m.size() > 0) sb.push_back(m[0]);
        model(ld, sh, cl, v);
        @(posedge ck);
        #1;
        loadIn   = 1'b0;
        shiftOut = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (top !== 8'd0 || count !== 3'd0 || empty !== 1'b1 ||
            full !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset: top=%0d cnt=%0d e=%b f=%b o=%b u=%b",
                     top, count, empty, full, overflow, underflow);
        end
        @(negedge ck);
        r = 1'b1;
        m.delete();
        sb.delete();
    endtask

    task automatic test_insert_pop();
        int v[4] = '{5, 9, 0, 9};
        int exp;
        foreach (v[i]) step(1, 0, 0, v[i]);
        checks++;
        if (top !== W'(mtop()) || count !== 3'(m.size()) || full !== 1'b1) begin
            errors++;
            $display("FAIL ins4: top=%0d cnt=%0d full=%b need %0d %0d 1",
                     top, count, full, mtop(), m.size());
        end
`ifndef PQ_MIN_EN
        checks++;
        if (top !== 8'd9) begin
            errors++;
            $display("FAIL ins4_top: got %0d need 9", top);
        end
`endif
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 0);
            exp = sb.pop_front();
            checks++;
            if (popped !== exp) begin
                errors++;
                $display("FAIL pop%0d: got %0d need %0d", i, popped, exp);
            end
        end
        checks++;
        if (empty !== 1'b1 || top !== 8'd0) begin
            errors++;
            $display("FAIL drained: empty=%b top=%0d need 1 0", empty, top);
        end
    endtask

    task automatic test_overflow();
        int v[4] = '{9, 7, 5, 3};
        int exp;
        foreach (v[i]) step(1, 0, 0, v[i]);
        step(1, 0, 0, 6);
        checks++;
        if (overflow !== e_ovf || count !== 3'd4 || top !== W'(mtop())) begin
            errors++;
            $display("FAIL ovf6: ovf=%b cnt=%0d top=%0d need %b 4 %0d",
                     overflow, count, top, e_ovf, mtop());
        end
        step(0, 0, 0, 0);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_pulse: got %b need 0", overflow);
        end
        step(1, 0, 0, 1);
        checks++;
        if (overflow !== 1'b1 || count !== 3'd4) begin
            errors++;
            $display("FAIL ovf1: ovf=%b cnt=%0d need 1 4", overflow, count);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 0);
            exp = sb.pop_front();
            checks++;
            if (popped !== exp) begin
                errors++;
                $display("FAIL ovf_pop%0d: got %0d need %0d", i, popped, exp);
            end
        end
    endtask

    task automatic test_underflow();
        step(0, 1, 0, 0);
        checks++;
        if (underflow !== 1'b1 || count !== 3'd0) begin
            errors++;
            $display("FAIL unf: unf=%b cnt=%0d need 1 0", underflow, count);
        end
        step(1, 1, 0, 4);
        checks++;
        if (underflow !== 1'b0 || top !== 8'd4 || count !== 3'd1) begin
            errors++;
            $display("FAIL repl_empty: unf=%b top=%0d cnt=%0d need 0 4 1",
                     underflow, top, count);
        end
    endtask

    task automatic test_replace();
        int v[3] = '{8, 6, 2};
        int exp;
        step(0, 0, 1, 0);
        foreach (v[i]) step(1, 0, 0, v[i]);
        step(1, 1, 0, 7);
        checks++;
        if (top !== W'(mtop()) || count !== 3'd3 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL repl7: top=%0d cnt=%0d ovf=%b need %0d 3 0",
                     top, count, overflow, mtop());
        end
        step(1, 1, 0, 1);
        checks++;
        if (top !== W'(mtop()) || count !== 3'd3) begin
            errors++;
            $display("FAIL repl1: top=%0d cnt=%0d need %0d 3", top, count, mtop());
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0);
            exp = sb.pop_front();
            checks++;
            if (popped !== exp) begin
                errors++;
                $display("FAIL repl_pop%0d: got %0d need %0d", i, popped, exp);
            end
        end
    endtask

    task automatic test_clear();
        step(1, 0, 0, 8);
        step(1, 0, 0, 6);
        step(1, 0, 1, 3);
        checks++;
        if (empty !== 1'b1 || count !== 3'd0 || top !== 8'd0 ||
            overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL clear: e=%b cnt=%0d top=%0d o=%b u=%b",
                     empty, count, top, overflow, underflow);
        end
    endtask

    task automatic test_async_reset();
        step(1, 0, 0, 8);
        step(1, 0, 0, 6);
        @(posedge ck);
        #2;
        r = 1'b0;
        #1;
        checks++;
        if (top !== 8'd0 || empty !== 1'b1 || count !== 3'd0 || full !== 1'b0) begin
            errors++;
            $display("FAIL async_rst: top=%0d e=%b cnt=%0d f=%b",
                     top, empty, count, full);
        end
        @(negedge ck);
        r = 1'b1;
        m.delete();
        sb.delete();
    endtask

    task automatic test_min_order();
        int v[3] = '{5, 2, 8};
        int exp;
        foreach (v[i]) step(1, 0, 0, v[i]);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0);
            exp = sb.pop_front();
            checks++;
            if (popped !== exp) begin
                errors++;
                $display("FAIL order_pop%0d: got %0d need %0d", i, popped, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        int sel;
        int exp;
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 19);
            if (sel == 0)      step(0, 0, 1, $urandom_range(0, 15));
            else if (sel < 9)  step(1, 0, 0, $urandom_range(0, 15));
            else if (sel < 15) step(0, 1, 0, 0);
            else if (sel < 18) step(1, 1, 0, $urandom_range(0, 15));
            else               step(0, 0, 0, 0);
            while (sb.size() > 0) begin
                exp = sb.pop_front();
                checks++;
                if (popped !== exp) begin
                    errors++;
                    $display("FAIL b2b_pop%0d: got %0d need %0d", n, popped, exp);
                end
            end
            checks++;
            if (top !== W'(mtop()) || count !== 3'(m.size()) ||
                overflow !== e_ovf || underflow !== e_unf ||
                empty !== (m.size() == 0) || full !== (m.size() == DEPTH)) begin
                errors++;
                $display("FAIL b2b%0d: top=%0d cnt=%0d o=%b u=%b need %0d %0d %b %b",
                         n, top, count, overflow, underflow,
                         mtop(), m.size(), e_ovf, e_unf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_insert_pop();
        test_overflow();
        test_underflow();
        test_replace();
        test_clear();
        test_async_reset();
        test_min_order();
        step(0, 0, 1, 0);
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
